// File: rtl/phy_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : phy_tx_pkg
// Purpose  : Shared symbol/word constants and link state encoding for PHY TX.
// Revision : 1.0
// ============================================================================
package phy_tx_pkg;

    localparam logic [7:0]  K_COM     = 8'hBC;
    localparam logic [7:0]  K_IDL     = 8'h7C;
    localparam logic [7:0]  K_SKP     = 8'h1C;

    localparam logic [31:0] COM_WORD  = {4{K_COM}};
    localparam logic [31:0] IDL_WORD  = {4{K_IDL}};
    localparam logic [31:0] SKP_WORD  = {4{K_SKP}};
    localparam logic [31:0] EIOS_WORD = {K_COM, K_IDL, K_IDL, K_IDL};

    localparam logic [3:0]  K_ALL     = 4'hF;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_TRAIN = 2'd1,
        ST_LINK  = 2'd2,
        ST_EIOS  = 2'd3
    } link_state_e;

endpackage
`default_nettype wire

// File: rtl/phy_tx_link_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : phy_tx_link_ctrl_if
// Purpose  : Upstream payload handshake and downstream TX word bus bundle.
// Revision : 1.0
// ============================================================================
interface phy_tx_link_ctrl_if;

    logic        active;
    logic        valid;
    logic [31:0] data_input;
    logic        in_ready;
    logic [31:0] tx_data;
    logic [3:0]  tx_k;
    logic        tx_valid;
    logic        payload_valid;
    logic        link_up;
    logic [1:0]  state_o;

    // Upstream/link-layer side
    modport master (
        output active, valid, data_input,
        input  in_ready, tx_data, tx_k, tx_valid, payload_valid, link_up, state_o
    );

    // Link controller side
    modport slave (
        input  active, valid, data_input,
        output in_ready, tx_data, tx_k, tx_valid, payload_valid, link_up, state_o
    );

endinterface
`default_nettype wire

// File: rtl/phy_tx_link_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : phy_tx_link_ctrl
// Purpose  : Link sequencer (train / link / EIOS) driving the 32-bit TX word bus.
// Revision : 1.0
// ============================================================================
module phy_tx_link_ctrl
    import phy_tx_pkg::*;
#(
    parameter int TRAIN_LEN    = 4,
    parameter int SKP_INTERVAL = 16,
    parameter int CNT_W        = 8
) (
    input  logic              clk_f,
    input  logic              reset,
    phy_tx_link_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] TRAIN_LAST = CNT_W'(TRAIN_LEN - 1);
    localparam logic [CNT_W-1:0] SKP_LAST   = CNT_W'(SKP_INTERVAL - 1);

    link_state_e      state_q, state_d;
    logic [CNT_W-1:0] train_cnt_q, train_cnt_d;
    logic [CNT_W-1:0] skp_cnt_q, skp_cnt_d;
    logic [31:0]      tx_data_q, tx_data_d;
    logic [3:0]       tx_k_q, tx_k_d;
    logic             tx_valid_q, tx_valid_d;
    logic             payload_valid_q, payload_valid_d;
    logic             link_up_q, link_up_d;
    logic             in_ready_w;
    logic             skp_due_w;

    assign skp_due_w = (skp_cnt_q == SKP_LAST);

    always_comb begin
        state_d         = state_q;
        train_cnt_d     = train_cnt_q;
        skp_cnt_d       = skp_cnt_q;
        tx_data_d       = '0;
        tx_k_d          = '0;
        tx_valid_d      = 1'b0;
        payload_valid_d = 1'b0;
        link_up_d       = 1'b0;
        in_ready_w      = 1'b0;

        case (state_q)
            ST_OFF: begin
                if (bus.active) begin
                    state_d     = ST_TRAIN;
                    train_cnt_d = '0;
                end
            end
            ST_TRAIN: begin
                tx_valid_d = 1'b1;
                tx_k_d     = K_ALL;
                if (!bus.active) begin
                    state_d   = ST_EIOS;
                    tx_data_d = EIOS_WORD;
                end else begin
                    tx_data_d = COM_WORD;
                    if (train_cnt_q == TRAIN_LAST) begin
                        state_d     = ST_LINK;
                        train_cnt_d = '0;
                        skp_cnt_d   = '0;
                    end else begin
                        train_cnt_d = train_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_LINK: begin
                tx_valid_d = 1'b1;
                tx_k_d     = K_ALL;
                if (!bus.active) begin
                    // Deactivation wins over a due SKP and over pending payload
                    state_d   = ST_EIOS;
                    tx_data_d = EIOS_WORD;
                end else begin
                    link_up_d = 1'b1;
                    if (skp_due_w) begin
                        tx_data_d = SKP_WORD;
                        skp_cnt_d = '0;
                    end else begin
                        skp_cnt_d  = skp_cnt_q + CNT_W'(1);
                        in_ready_w = 1'b1;
                        if (bus.valid) begin
                            tx_data_d       = bus.data_input;
                            tx_k_d          = '0;
                            payload_valid_d = 1'b1;
                        end else begin
                            tx_data_d = IDL_WORD;
                        end
                    end
                end
            end
            ST_EIOS: begin
                state_d = ST_OFF;
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    always_ff @(posedge clk_f) begin
        if (!reset) begin
            state_q         <= ST_OFF;
            train_cnt_q     <= '0;
            skp_cnt_q       <= '0;
            tx_data_q       <= '0;
            tx_k_q          <= '0;
            tx_valid_q      <= 1'b0;
            payload_valid_q <= 1'b0;
            link_up_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            train_cnt_q     <= train_cnt_d;
            skp_cnt_q       <= skp_cnt_d;
            tx_data_q       <= tx_data_d;
            tx_k_q          <= tx_k_d;
            tx_valid_q      <= tx_valid_d;
            payload_valid_q <= payload_valid_d;
            link_up_q       <= link_up_d;
        end
    end

    assign bus.in_ready      = in_ready_w;
    assign bus.tx_data       = tx_data_q;
    assign bus.tx_k          = tx_k_q;
    assign bus.tx_valid      = tx_valid_q;
    assign bus.payload_valid = payload_valid_q;
    assign bus.link_up       = link_up_q;
    assign bus.state_o       = state_q;

endmodule
`default_nettype wire

// File: doc/phy_tx_link_ctrl.md
Name: phy_tx_link_ctrl

Overview:
- Link-level sequencer in front of the PHY TX byte-striping/serializer datapath.
- Owns what goes onto the 32-bit TX word bus each clk_f cycle:
  - training COM words after activation;
  - user data when valid;
  - IDL fill words when idle;
  - periodic SKP words;
  - an EIOS word when the link is deactivated.
- Upstream is backpressured via in_ready; downstream sees a registered word plus a per-byte K-character mask.

Parameters:
- TRAIN_LEN, 4, number of COM words sent in TRAIN before entering LINK (1..255).
- SKP_INTERVAL, 16, LINK words between SKP insertions (SKP word counted as one of them; 2..255).
- CNT_W, 8, width of internal train/skip counters.

Ports:
- clk_f  input  1  sole clock; all logic on posedge.
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on posedge clk_f).
- active  input  1  link enable request from upper layer.
- valid  input  1  data_input holds a payload word.
- data_input  input  32  payload word.
- in_ready  output  1  combinational; payload accepted this cycle iff valid && in_ready.
- tx_data  output  32  registered word to the striping datapath.
- tx_k  output  4  registered; bit i = 1 means byte i of tx_data is a K-character.
- tx_valid  output  1  registered; a word (data or control) is driven this cycle.
- payload_valid  output  1  registered; tx_data is user payload.
- link_up  output  1  registered; 1 while in LINK.
- state_o  output  2  current state encoding, for debug/verification.

Behaviour:
- Reset (reset==0 at posedge):
  - next state OFF;
  - tx_data=0, tx_k=0, tx_valid=0, payload_valid=0, link_up=0;
  - counters cleared.
  - This overrides everything, including mid-TRAIN, mid-LINK and during EIOS.
- States: OFF=0, TRAIN=1, LINK=2, EIOS=3.
- in_ready=1 only when state==LINK, active==1 and no SKP is due this cycle; 0 otherwise.
- Output latency: 1 cycle. The word decided in cycle n appears on tx_* after posedge n+1.
- OFF:
  - outputs all zero;
  - active==1 -> TRAIN with train_cnt=0.
- TRAIN:
  - each cycle drive tx_data=32'hBCBCBCBC, tx_k=4'hF, tx_valid=1, payload_valid=0;
  - train_cnt increments;
  - after TRAIN_LEN COM words -> LINK with skp_cnt=0;
  - active==0 at any cycle -> EIOS instead, taking priority over completion.
- LINK (link_up=1 on the registered output from the first LINK word):
  - skp_cnt increments every LINK cycle.
  - When skp_cnt==SKP_INTERVAL-1: drive SKP word 32'h1C1C1C1C, tx_k=4'hF, payload_valid=0; skp_cnt wraps to 0; in_ready=0, so a pending valid word is held upstream and not lost.
  - Else if valid: tx_data=data_input, tx_k=0, payload_valid=1.
  - Else: IDL word 32'h7C7C7C7C, tx_k=4'hF, payload_valid=0.
  - tx_valid=1 every LINK cycle.
  - active==0 -> EIOS; the current cycle's word is not accepted (in_ready=0).
- EIOS:
  - exactly one word 32'hBC7C7C7C, tx_k=4'hF, tx_valid=1, payload_valid=0, link_up=0;
  - then -> OFF unconditionally, even if active has returned. Re-activation always retrains.
- Simultaneous events:
  - active falling takes priority over SKP due and over TRAIN completion;
  - SKP due takes priority over valid.
- Counter widths: CNT_W must hold TRAIN_LEN and SKP_INTERVAL. Counters compare against parameter-1 and never overflow.

Decomposition:
- Shared package phy_tx_pkg holds:
  - symbol constants: K_COM=8'hBC, K_IDL=8'h7C, K_SKP=8'h1C;
  - 32-bit word constants COM_WORD, IDL_WORD, SKP_WORD, EIOS_WORD;
  - state encodings OFF/TRAIN/LINK/EIOS.
- No sub-module is needed: FSM, two counters and an output register stage live in a single module. The optional output register can be factored as phy_tx_word_reg if reused by the striping block.

Test Plan:
- Reset 0 for 2 cycles, then 1 with active=0 -> tx_valid=0, tx_data=0, state_o=0 throughout.
- active=1 at cycle 0, valid=0:
  - tx_data=BCBCBCBC with tx_k=F for 4 cycles;
  - then 7C7C7C7C, link_up=1;
  - the 16th LINK word is 1C1C1C1C.
- In LINK, valid=1 with data AAAA1234, 12345678, BBBBAAAA -> same words on tx_data one cycle later, tx_k=0, payload_valid=1.
- valid held high with FFEEEEEE across SKP-due cycle:
  - in_ready=0 that cycle, tx_data=1C1C1C1C;
  - next cycle FFEEEEEE is sent exactly once.
- active drops in TRAIN after 2 COM words -> one BC7C7C7C word, then OFF. Re-assert active -> full 4-word TRAIN restarts.
- reset=0 mid-LINK while valid=1 -> next cycle all outputs 0, state OFF, in_ready=0.
